// File: rtl/nco_sweep_pkg.sv
// Shared FSM encoding and default widths for the NCO frequency sweeper.
// NCO_SWEEP_BIDIR_EN adds the DOWN state for triangle sweeps.
package nco_sweep_pkg;

    localparam int unsigned DefaultW  = 32;
    localparam int unsigned DefaultDW = 16;

`ifdef NCO_SWEEP_BIDIR_EN
    typedef enum logic [2:0] {StIdle, StLoad, StDwell, StStep, StDown} state_e;
`else
    typedef enum logic [2:0] {StIdle, StLoad, StDwell, StStep} state_e;
`endif

endpackage

// File: rtl/nco_sweep_dwell.sv
// Dwell counter: counts sample strobes while enabled and flags the strobe that
// completes max(dwell, 1) counts, then wraps to zero.
module nco_sweep_dwell
    import nco_sweep_pkg::*;
#(
    parameter int unsigned DW = DefaultDW
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          clr_i,
    input  logic          en_i,
    input  logic          ce_i,
    input  logic [DW-1:0] dwell_i,
    output logic          tc_o
);

    logic [DW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] last;

    always_comb begin
        // A dwell of zero behaves like a dwell of one.
        last  = (dwell_i == '0) ? '0 : dwell_i - DW'(1);
        tc_o  = en_i && ce_i && (cnt_q == last);
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && ce_i) begin
            cnt_d = tc_o ? '0 : cnt_q + DW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/nco_sweep.sv
// Stepped-frequency sweep controller feeding an NCO phase-step word.
// Define NCO_SWEEP_BIDIR_EN for triangle (up then down) sweeps.
module nco_sweep
    import nco_sweep_pkg::*;
#(
    parameter int unsigned W  = DefaultW,
    parameter int unsigned DW = DefaultDW
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_start,
    input  logic          i_abort,
    input  logic          i_continuous,
    input  logic [W-1:0]  i_f_start,
    input  logic [W-1:0]  i_f_stop,
    input  logic [W-1:0]  i_f_incr,
    input  logic [DW-1:0] i_dwell,
    input  logic          i_ce,
    output logic          o_ld,
    output logic [W-1:0]  o_dphase,
    output logic          o_busy,
    output logic          o_done
);

    state_e        state_q, state_d;
    logic [W-1:0]  freq_q, freq_d;
    logic [W-1:0]  start_q, start_d;
    logic [W-1:0]  stop_q, stop_d;
    logic [W-1:0]  incr_q, incr_d;
    logic [W-1:0]  dphase_q, dphase_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic          cont_q, cont_d;
    logic          done_q, done_d;
    logic          dwell_tc, dwell_clr, dwell_en;
    logic [W:0]    nxt;
    logic          up_end;
`ifdef NCO_SWEEP_BIDIR_EN
    logic [W:0]    prv;
    logic          down_end;
    logic          dir_down_q, dir_down_d;
`endif

    nco_sweep_dwell #(
        .DW(DW)
    ) u_dwell (
        .clk_i   (i_clk),
        .reset_i (i_reset),
        .clr_i   (dwell_clr),
        .en_i    (dwell_en),
        .ce_i    (i_ce),
        .dwell_i (dwell_q),
        .tc_o    (dwell_tc)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= StIdle;
            freq_q     <= '0;
            start_q    <= '0;
            stop_q     <= '0;
            incr_q     <= '0;
            dphase_q   <= '0;
            dwell_q    <= '0;
            cont_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef NCO_SWEEP_BIDIR_EN
            dir_down_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            freq_q     <= freq_d;
            start_q    <= start_d;
            stop_q     <= stop_d;
            incr_q     <= incr_d;
            dphase_q   <= dphase_d;
            dwell_q    <= dwell_d;
            cont_q     <= cont_d;
            done_q     <= done_d;
`ifdef NCO_SWEEP_BIDIR_EN
            dir_down_q <= dir_down_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        freq_d  = freq_q;
        start_d = start_q;
        stop_d  = stop_q;
        incr_d  = incr_q;
        dwell_d = dwell_q;
        cont_d  = cont_q;
        done_d  = 1'b0;
        // The carry bit makes W-bit overflow compare above any stop value.
        nxt     = {1'b0, freq_q} + {1'b0, incr_q};
        up_end  = nxt > {1'b0, stop_q};
`ifdef NCO_SWEEP_BIDIR_EN
        dir_down_d = dir_down_q;
        prv        = {1'b0, freq_q} - {1'b0, incr_q};
        down_end   = prv[W] || (prv[W-1:0] < start_q);
`endif
        if (state_q != StIdle && i_abort) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (i_start && !i_abort) begin
                        start_d = i_f_start;
                        stop_d  = i_f_stop;
                        incr_d  = i_f_incr;
                        dwell_d = i_dwell;
                        cont_d  = i_continuous;
                        freq_d  = i_f_start;
                        state_d = StLoad;
`ifdef NCO_SWEEP_BIDIR_EN
                        dir_down_d = 1'b0;
`endif
                    end
                end
                StLoad: state_d = StDwell;
                StDwell: begin
                    // A zero increment parks the sweep on its first frequency.
                    if (dwell_tc && incr_q != '0) begin
`ifdef NCO_SWEEP_BIDIR_EN
                        state_d = dir_down_q ? StDown : StStep;
`else
                        state_d = StStep;
`endif
                    end
                end
                StStep: begin
                    if (up_end) begin
`ifdef NCO_SWEEP_BIDIR_EN
                        dir_down_d = 1'b1;
                        state_d    = StDown;
`else
                        if (cont_q) begin
                            freq_d  = start_q;
                            state_d = StLoad;
                        end else begin
                            done_d  = 1'b1;
                            state_d = StIdle;
                        end
`endif
                    end else begin
                        freq_d  = nxt[W-1:0];
                        state_d = StLoad;
                    end
                end
`ifdef NCO_SWEEP_BIDIR_EN
                StDown: begin
                    if (down_end) begin
                        if (cont_q) begin
                            freq_d     = start_q;
                            dir_down_d = 1'b0;
                            state_d    = StLoad;
                        end else begin
                            done_d  = 1'b1;
                            state_d = StIdle;
                        end
                    end else begin
                        freq_d  = prv[W-1:0];
                        state_d = StLoad;
                    end
                end
`endif
                default: state_d = StIdle;
            endcase
        end
        dphase_d = (state_d == StLoad) ? freq_d : dphase_q;
    end

    always_comb begin
        o_ld      = (state_q == StLoad);
        o_busy    = (state_q != StIdle);
        o_done    = done_q;
        o_dphase  = dphase_q;
        dwell_clr = (state_q == StLoad);
        dwell_en  = (state_q == StDwell);
    end

endmodule

// File: doc/nco_sweep.md
NCO_SWEEP -- requirements
Module: nco_sweep

Interface
REQ-001 SHALL have parameter W, default 32, meaning phase-step word width; it matches the downstream NCO's i_dphase width.
REQ-002 SHALL have parameter DW, default 16, meaning dwell counter width.
REQ-003 SHALL have port i_clk  in  1  meaning the single clock; all logic is clocked on its rising edge.
REQ-004 SHALL have port i_reset  in  1  meaning synchronous, active-high reset.
REQ-005 SHALL have port i_start  in  1  meaning a one-cycle request to begin a sweep.
REQ-006 SHALL have port i_abort  in  1  meaning terminate the sweep immediately.
REQ-007 SHALL have port i_continuous  in  1  meaning 1 = restart at the endpoint, 0 = single sweep.
REQ-008 SHALL have ports i_f_start, i_f_stop and i_f_incr  in  W  meaning start step, stop step and unsigned increment.
REQ-009 SHALL have port i_dwell  in  DW  meaning sample strobes per frequency; a value of 0 is treated as 1.
REQ-010 SHALL have port i_ce  in  1  meaning the sample strobe, the same strobe that drives the NCO's i_ce.
REQ-011 SHALL have port o_ld  out  1  meaning load strobe to the NCO's i_ld.
REQ-012 SHALL have port o_dphase  out  W  meaning phase step to the NCO's i_dphase.
REQ-013 SHALL have port o_busy  out  1  meaning high in every state except IDLE.
REQ-014 SHALL have port o_done  out  1  meaning a one-cycle pulse at normal sweep completion.

Function
REQ-015 SHALL implement the FSM states IDLE, LOAD, DWELL and STEP; state DOWN is added only when the configuration macro is defined.
REQ-016 When i_start is high in IDLE, the block SHALL latch i_f_start, i_f_stop, i_f_incr, i_dwell and i_continuous into shadow registers, set freq = i_f_start, and go to LOAD.
REQ-017 Shadow registers SHALL be unaffected by input changes while o_busy is high.
REQ-018 i_start SHALL be ignored while o_busy is high.
REQ-019 In LOAD, o_ld SHALL be high for exactly one cycle, with o_dphase = freq; the dwell counter SHALL clear, and the next state SHALL be DWELL.
REQ-020 In DWELL, the dwell counter SHALL increment on each i_ce; the FSM SHALL go to STEP on the i_ce that completes max(dwell,1) strobes.
REQ-021 Cycles without i_ce SHALL NOT advance the dwell counter.
REQ-022 In STEP, the block SHALL compute nxt = freq + incr at W+1 bits.
REQ-023 If nxt > f_stop or nxt overflows W bits, the endpoint is reached: if continuous, freq SHALL become f_start and the FSM SHALL go to LOAD; otherwise o_done SHALL pulse for one cycle and the FSM SHALL go to IDLE.
REQ-024 If the endpoint is not reached, freq SHALL become nxt[W-1:0] and the FSM SHALL go to LOAD.
REQ-025 Each frequency SHALL be presented for max(dwell,1) i_ce strobes plus 2 clocks of STEP/LOAD overhead.
REQ-026 If incr == 0, the block SHALL remain in DWELL after the first LOAD with no further o_ld, until abort or reset.
REQ-027 If f_stop < f_start, exactly one LOAD of f_start SHALL occur, followed by the endpoint action.
REQ-028 i_abort in any non-IDLE state SHALL force IDLE on the next edge, with no o_done, no o_ld, and o_dphase holding its last value.
REQ-029 When i_abort and i_start are both high in IDLE, abort SHALL win and the block SHALL remain in IDLE.
REQ-030 Latency: i_start sampled at edge k SHALL produce o_ld high in the cycle after edge k.
REQ-031 o_dphase SHALL be registered and change only when entering LOAD.

Reset
REQ-032 On i_reset at a clock edge, the state SHALL become IDLE, o_ld = 0, o_done = 0, o_busy = 0, o_dphase = 0, and all counters and shadow registers SHALL clear.
REQ-033 Reset SHALL take priority over i_abort and i_start, including when asserted mid-sweep.

Configuration
REQ-034 Macro NCO_SWEEP_BIDIR_EN SHALL select between unidirectional and triangle sweeps.
REQ-035 With NCO_SWEEP_BIDIR_EN defined, the up-endpoint SHALL enter DOWN; DOWN steps freq = freq - incr through LOAD/DWELL.
REQ-036 With NCO_SWEEP_BIDIR_EN defined, a borrow or freq - incr < f_start SHALL be the down-endpoint: continuous returns to up-sweep from f_start; single pulses o_done and goes to IDLE.
REQ-037 With NCO_SWEEP_BIDIR_EN defined, f_stop itself SHALL be loaded only if it is hit exactly.
REQ-038 Without NCO_SWEEP_BIDIR_EN, the DOWN state and subtractor SHALL be absent and behaviour SHALL be as in REQ-023.

Structure
REQ-039 Package nco_sweep_pkg SHALL hold the FSM state encodings and the default W and DW constants.
REQ-040 Sub-module nco_sweep_dwell SHALL hold the dwell counter: clear, i_ce-gated count, and terminal-count flag.

Verification
REQ-041 Scenario: start=100, stop=400, incr=100, dwell=3, single, i_ce always high -> o_ld with 100, 200, 300, 400, each 5 clocks apart, then one o_done pulse and o_busy low.
REQ-042 Scenario: same setup with continuous=1 -> the sequence 100..400 repeats, with LOAD of 100 following 400, and no o_done.
REQ-043 Scenario: i_abort during DWELL at freq 200 -> IDLE next cycle, o_dphase stays 200, no o_done; a subsequent start reloads 100.
REQ-044 Scenario: incr=0, start=50 -> one o_ld with 50, then no further o_ld for 1000 cycles; dwell=0 behaves as dwell=1.
REQ-045 Scenario: start=32'hFFFF_FF00, stop=32'hFFFF_FFFF, incr=32'h200 -> a single load, then overflow is detected as the endpoint and o_done pulses.
REQ-046 Scenario: i_reset mid-sweep with i_ce toggling 1-in-4 -> all outputs 0 the cycle after reset; dwell counts only the i_ce strobes. With NCO_SWEEP_BIDIR_EN, start=100, stop=300, incr=100 -> loads 100, 200, 300, 200, 100, then o_done.
